// File: rtl/datapath_if.sv
// Control-unit <-> datapath bundle: memory bus, I/O ports, load strobes and status outputs.
// The datapath connects through the slave modport and the control unit through master.
interface datapath_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [DW-1:0] readdata;
  logic [DW-1:0] IN;
  logic          IRload;
  logic          MRload;
  logic          PCload;
  logic          Aload;
  logic          RFwr;
  logic          outen;
  logic          MemInst;
  logic [2:0]    Jmpsel;
  logic [1:0]    Asel;
  logic [2:0]    ALUsel;
  logic [1:0]    Shiftsel;
  logic          push;
  logic          pop;
  logic [DW-1:0] accout;
  logic [DW-1:0] OUT;
  logic [DW-1:0] INSTR;
  logic [AW-1:0] address;
  logic          zflag;
  logic          cflag;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  modport master (
    output readdata, IN, IRload, MRload, PCload, Aload, RFwr, outen, MemInst,
           Jmpsel, Asel, ALUsel, Shiftsel, push, pop,
    input  accout, OUT, INSTR, address, zflag, cflag, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  readdata, IN, IRload, MRload, PCload, Aload, RFwr, outen, MemInst,
           Jmpsel, Asel, ALUsel, Shiftsel, push, pop,
    output accout, OUT, INSTR, address, zflag, cflag, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/datapath_gen.sv
// Parametrised accumulator datapath: acc, register file, ALU/shifter, OUT, IR, MA, PC, Z/C flags.
// Define DATAPATH_STACK_EN to compile in the CALL/RET return-address stack.
module datapath_gen #(
  parameter int DW     = 8,
  parameter int AW     = 6,
  parameter int NREG   = 8,
  parameter int SDEPTH = 4
) (
  input logic     clk,
  input logic     reset,
  datapath_if.slave dp
);
  localparam int RI = $clog2(NREG);

  logic [DW-1:0] acc_reg;
  logic [DW-1:0] out_reg;
  logic [DW-1:0] ir_reg;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] ma_reg;
  logic          zflag_reg;
  logic          cflag_reg;
  logic [DW-1:0] rf_reg [NREG];

  logic [RI-1:0] rf_idx;
  logic [DW-1:0] rfout;
  logic [DW:0]   alu_full;
  logic [DW-1:0] alu_res;
  logic          carry_next;
  logic [DW-1:0] shift_res;
  logic [DW-1:0] acc_next;
  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] stack_top;

  assign rf_idx = ir_reg[RI-1:0];
  assign rfout  = rf_reg[rf_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rf_reg[gi] <= '0;
        end else if (dp.RFwr && (rf_idx == RI'(gi))) begin
          rf_reg[gi] <= acc_reg;
        end
      end
    end
  endgenerate

  // One extra result bit carries the add carry / subtract borrow; logic ops leave it 0.
  always_comb begin
    alu_full = {1'b0, acc_reg};
    case (dp.ALUsel)
      3'd1:    alu_full = {1'b0, acc_reg} + {1'b0, rfout};
      3'd2:    alu_full = {1'b0, acc_reg} - {1'b0, rfout};
      3'd3:    alu_full = {1'b0, acc_reg & rfout};
      3'd4:    alu_full = {1'b0, acc_reg | rfout};
      3'd5:    alu_full = {1'b0, acc_reg ^ rfout};
      3'd6:    alu_full = {1'b0, ~acc_reg};
      3'd7:    alu_full = {1'b0, rfout};
      default: alu_full = {1'b0, acc_reg};
    endcase
  end

  assign alu_res    = alu_full[DW-1:0];
  assign carry_next = alu_full[DW];

  always_comb begin
    shift_res = alu_res;
    case (dp.Shiftsel)
      2'd1:    shift_res = {alu_res[DW-2:0], 1'b0};
      2'd2:    shift_res = {1'b0, alu_res[DW-1:1]};
      2'd3:    shift_res = {alu_res[0], alu_res[DW-1:1]};
      default: shift_res = alu_res;
    endcase
  end

  always_comb begin
    acc_next = shift_res;
    case (dp.Asel)
      2'd1:    acc_next = rfout;
      2'd2:    acc_next = dp.IN;
      2'd3:    acc_next = dp.readdata;
      default: acc_next = shift_res;
    endcase
  end

  // PC arithmetic wraps silently at AW bits.
  assign pc_plus1 = pc_reg + AW'(1);

  always_comb begin
    pc_next = pc_plus1;
    case (dp.Jmpsel)
      3'd1:    pc_next = dp.readdata[AW-1:0];
      3'd2:    pc_next = pc_reg - ir_reg[AW-1:0];
      3'd3:    pc_next = pc_reg + ir_reg[AW-1:0];
      3'd4:    pc_next = stack_top;
      default: pc_next = pc_plus1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      out_reg   <= '0;
      ir_reg    <= '0;
      pc_reg    <= '0;
      ma_reg    <= '0;
      zflag_reg <= 1'b0;
      cflag_reg <= 1'b0;
    end else begin
      if (dp.Aload)  acc_reg <= acc_next;
      if (dp.outen)  out_reg <= acc_reg;
      if (dp.IRload) ir_reg  <= dp.readdata;
      if (dp.MRload) ma_reg  <= dp.readdata[AW-1:0];
      if (dp.PCload) pc_reg  <= pc_next;
      if (dp.Aload && (dp.Asel == 2'd0)) begin
        zflag_reg <= (shift_res == '0);
        cflag_reg <= carry_next;
      end
    end
  end

  assign dp.accout  = acc_reg;
  assign dp.OUT     = out_reg;
  assign dp.INSTR   = ir_reg;
  assign dp.address = dp.MemInst ? ma_reg : pc_reg;
  assign dp.zflag   = zflag_reg;
  assign dp.cflag   = cflag_reg;

`ifdef DATAPATH_STACK_EN
  localparam int CW = $clog2(SDEPTH + 1);
  localparam int SI = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  logic [CW-1:0] count_reg;
  logic          err_reg;
  logic [AW-1:0] stack_mem [SDEPTH];
  logic          is_full;
  logic          is_empty;
  logic [CW-1:0] top_ptr;
  logic          do_push;
  logic          do_pop;
  logic          do_replace;

  assign is_full  = (count_reg == CW'(SDEPTH));
  assign is_empty = (count_reg == '0);
  assign top_ptr  = count_reg - CW'(1);
  assign stack_top = is_empty ? '0 : stack_mem[top_ptr[SI-1:0]];

  // push+pop on a non-empty stack rewrites the top in place; on an empty one it is a plain push.
  assign do_replace = dp.push && dp.pop && !is_empty;
  assign do_push    = dp.push && !(dp.pop && !is_empty);
  assign do_pop     = dp.pop && !dp.push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (do_push) begin
      if (is_full) err_reg <= 1'b1;
      else         count_reg <= count_reg + CW'(1);
    end else if (do_pop) begin
      if (is_empty) err_reg <= 1'b1;
      else          count_reg <= count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_push && !is_full) stack_mem[count_reg[SI-1:0]] <= pc_plus1;
      else if (do_replace)     stack_mem[top_ptr[SI-1:0]]   <= pc_plus1;
    end
  end

  assign dp.stack_full  = is_full;
  assign dp.stack_empty = is_empty;
  assign dp.stack_err   = err_reg;
`else
  localparam int unused_sdepth = SDEPTH;
  logic unused_stack_strobes;

  assign unused_stack_strobes = dp.push ^ dp.pop;
  assign stack_top      = pc_plus1;
  assign dp.stack_full  = 1'b0;
  assign dp.stack_empty = 1'b1;
  assign dp.stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_gen.sv
// Directed bench for datapath_gen: reset, ALU flags, shifter, RF/OUT, PC wrap, return stack.
// Stack expectations follow whether DATAPATH_STACK_EN is defined for the build.
module tb_datapath_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  datapath_if #(.DW(8), .AW(6)) dp ();

  datapath_gen #(.DW(8), .AW(6), .NREG(8), .SDEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic clear_strobes();
    dp.IRload = 0; dp.MRload = 0; dp.PCload = 0; dp.Aload = 0; dp.RFwr = 0; dp.outen = 0;
    dp.MemInst = 0; dp.Jmpsel = 3'd0; dp.Asel = 2'd0; dp.ALUsel = 3'd0; dp.Shiftsel = 2'd0;
    dp.push = 0; dp.pop = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    clear_strobes();
    $display("cycle %0d: addr=%h acc=%h z=%b c=%b full=%b empty=%b err=%b", cyc, dp.address,
             dp.accout, dp.zflag, dp.cflag, dp.stack_full, dp.stack_empty, dp.stack_err);
  endtask

  task automatic load_acc(input logic [7:0] v);
    dp.IN = v; dp.Asel = 2'd2; dp.Aload = 1; tick();
  endtask

  task automatic load_ir(input logic [7:0] v);
    dp.readdata = v; dp.IRload = 1; tick();
  endtask

  task automatic load_pc(input logic [7:0] v);
    dp.readdata = v; dp.Jmpsel = 3'd1; dp.PCload = 1; tick();
  endtask

  task automatic alu_op(input logic [2:0] alu, input logic [1:0] sh);
    dp.ALUsel = alu; dp.Shiftsel = sh; dp.Asel = 2'd0; dp.Aload = 1; tick();
  endtask

  task automatic test_reset();
    clear_strobes();
    dp.readdata = 8'h00; dp.IN = 8'h00;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dp.accout !== 8'h00) begin n_bad++; $display("FAIL rst_acc: got %h want 00", dp.accout); end
    n_cmp++; if (dp.OUT !== 8'h00) begin n_bad++; $display("FAIL rst_out: got %h want 00", dp.OUT); end
    n_cmp++; if (dp.INSTR !== 8'h00) begin n_bad++; $display("FAIL rst_ir: got %h want 00", dp.INSTR); end
    n_cmp++; if (dp.address !== 6'h00) begin n_bad++; $display("FAIL rst_addr: got %h want 00", dp.address); end
    n_cmp++; if ({dp.zflag, dp.cflag} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {dp.zflag, dp.cflag}); end
    n_cmp++; if ({dp.stack_full, dp.stack_empty, dp.stack_err} !== 3'b010) begin n_bad++; $display("FAIL rst_stack: got %b want 010", {dp.stack_full, dp.stack_empty, dp.stack_err}); end
    reset = 0;
    dp.Asel = 2'd1; dp.Aload = 1; tick();
    n_cmp++; if (dp.accout !== 8'h00) begin n_bad++; $display("FAIL rst_rf0: got %h want 00", dp.accout); end
  endtask

  task automatic test_alu_flags();
    load_ir(8'h01); load_acc(8'h20); dp.RFwr = 1; tick();
    load_acc(8'hF0); alu_op(3'd1, 2'd0);
    n_cmp++; if ({dp.accout, dp.zflag, dp.cflag} !== {8'h10, 1'b0, 1'b1}) begin n_bad++; $display("FAIL add_carry: got %h z%b c%b want 10 z0 c1", dp.accout, dp.zflag, dp.cflag); end
    load_ir(8'h02); dp.RFwr = 1; tick();
    alu_op(3'd2, 2'd0);
    n_cmp++; if ({dp.accout, dp.zflag, dp.cflag} !== {8'h00, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sub_zero: got %h z%b c%b want 00 z1 c0", dp.accout, dp.zflag, dp.cflag); end
    load_acc(8'h05); alu_op(3'd2, 2'd0);
    n_cmp++; if ({dp.accout, dp.zflag, dp.cflag} !== {8'hF5, 1'b0, 1'b1}) begin n_bad++; $display("FAIL sub_borrow: got %h z%b c%b want f5 z0 c1", dp.accout, dp.zflag, dp.cflag); end
    load_acc(8'h00);
    n_cmp++; if ({dp.zflag, dp.cflag} !== 2'b01) begin n_bad++; $display("FAIL flags_hold: got z%b c%b want z0 c1", dp.zflag, dp.cflag); end
    load_acc(8'hF0); alu_op(3'd3, 2'd0);
    n_cmp++; if ({dp.accout, dp.zflag, dp.cflag} !== {8'h10, 1'b0, 1'b0}) begin n_bad++; $display("FAIL and_op: got %h z%b c%b want 10 z0 c0", dp.accout, dp.zflag, dp.cflag); end
    load_acc(8'h03); alu_op(3'd4, 2'd0);
    n_cmp++; if (dp.accout !== 8'h13) begin n_bad++; $display("FAIL or_op: got %h want 13", dp.accout); end
    load_acc(8'h10); alu_op(3'd5, 2'd0);
    n_cmp++; if ({dp.accout, dp.zflag} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL xor_op: got %h z%b want 00 z1", dp.accout, dp.zflag); end
    alu_op(3'd6, 2'd0);
    n_cmp++; if ({dp.accout, dp.zflag} !== {8'hFF, 1'b0}) begin n_bad++; $display("FAIL not_op: got %h z%b want ff z0", dp.accout, dp.zflag); end
    alu_op(3'd7, 2'd0);
    n_cmp++; if (dp.accout !== 8'h10) begin n_bad++; $display("FAIL pass_r: got %h want 10", dp.accout); end
    load_acc(8'hF0); alu_op(3'd1, 2'd0);
    n_cmp++; if ({dp.accout, dp.zflag, dp.cflag} !== {8'h00, 1'b1, 1'b1}) begin n_bad++; $display("FAIL add_wrap: got %h z%b c%b want 00 z1 c1", dp.accout, dp.zflag, dp.cflag); end
  endtask

  task automatic test_shifter();
    load_acc(8'h81); alu_op(3'd0, 2'd3);
    n_cmp++; if (dp.accout !== 8'hC0) begin n_bad++; $display("FAIL rotr_1: got %h want c0", dp.accout); end
    alu_op(3'd0, 2'd3);
    n_cmp++; if (dp.accout !== 8'h60) begin n_bad++; $display("FAIL rotr_2: got %h want 60", dp.accout); end
    load_acc(8'h81); alu_op(3'd0, 2'd1);
    n_cmp++; if ({dp.accout, dp.cflag} !== {8'h02, 1'b0}) begin n_bad++; $display("FAIL shl: got %h c%b want 02 c0", dp.accout, dp.cflag); end
    load_acc(8'h81); alu_op(3'd0, 2'd2);
    n_cmp++; if (dp.accout !== 8'h40) begin n_bad++; $display("FAIL shr: got %h want 40", dp.accout); end
    load_acc(8'h80); alu_op(3'd0, 2'd1);
    n_cmp++; if ({dp.accout, dp.zflag} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL shl_zero: got %h z%b want 00 z1", dp.accout, dp.zflag); end
    load_acc(8'h30); alu_op(3'd1, 2'd1);
    n_cmp++; if (dp.accout !== 8'h80) begin n_bad++; $display("FAIL add_shl: got %h want 80", dp.accout); end
  endtask

  task automatic test_rf_out();
    load_ir(8'h0B); load_acc(8'h11);
    dp.RFwr = 1; dp.IN = 8'h22; dp.Asel = 2'd2; dp.Aload = 1; tick();
    n_cmp++; if (dp.accout !== 8'h22) begin n_bad++; $display("FAIL wr_and_load_acc: got %h want 22", dp.accout); end
    dp.Asel = 2'd1; dp.Aload = 1; tick();
    n_cmp++; if (dp.accout !== 8'h11) begin n_bad++; $display("FAIL rf_old_acc: got %h want 11", dp.accout); end
    n_cmp++; if (dp.INSTR !== 8'h0B) begin n_bad++; $display("FAIL instr: got %h want 0b", dp.INSTR); end
    dp.outen = 1; tick();
    load_acc(8'h33);
    n_cmp++; if (dp.OUT !== 8'h11) begin n_bad++; $display("FAIL out_reg: got %h want 11", dp.OUT); end
    dp.readdata = 8'hA7; dp.Asel = 2'd3; dp.Aload = 1; tick();
    n_cmp++; if (dp.accout !== 8'hA7) begin n_bad++; $display("FAIL acc_readdata: got %h want a7", dp.accout); end
  endtask

  task automatic test_pc_wrap();
    load_pc(8'd62);
    n_cmp++; if (dp.address !== 6'd62) begin n_bad++; $display("FAIL pc_load: got %0d want 62", dp.address); end
    load_ir(8'h05);
    dp.Jmpsel = 3'd3; dp.PCload = 1; tick();
    n_cmp++; if (dp.address !== 6'd3) begin n_bad++; $display("FAIL pc_add_wrap: got %0d want 3", dp.address); end
    load_pc(8'd2);
    dp.Jmpsel = 3'd2; dp.PCload = 1; tick();
    n_cmp++; if (dp.address !== 6'd61) begin n_bad++; $display("FAIL pc_sub_wrap: got %0d want 61", dp.address); end
    load_pc(8'd63);
    dp.Jmpsel = 3'd0; dp.PCload = 1; tick();
    n_cmp++; if (dp.address !== 6'd0) begin n_bad++; $display("FAIL pc_inc_wrap: got %0d want 0", dp.address); end
    dp.Jmpsel = 3'd5; dp.PCload = 1; tick();
    tick();
    n_cmp++; if (dp.address !== 6'd1) begin n_bad++; $display("FAIL pc_sel5_hold: got %0d want 1", dp.address); end
    dp.readdata = 8'hEA; dp.MRload = 1; tick();
    dp.MemInst = 1; #1;
    n_cmp++; if (dp.address !== 6'h2A) begin n_bad++; $display("FAIL ma_addr: got %h want 2a", dp.address); end
    dp.MemInst = 0;
  endtask

  task automatic test_stack();
`ifdef DATAPATH_STACK_EN
    load_pc(8'h10);
    dp.push = 1; dp.Jmpsel = 3'd1; dp.readdata = 8'h30; dp.PCload = 1; tick();
    n_cmp++; if ({dp.address, dp.stack_empty} !== {6'h30, 1'b0}) begin n_bad++; $display("FAIL call: got %h e%b want 30 e0", dp.address, dp.stack_empty); end
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if ({dp.address, dp.stack_empty} !== {6'h11, 1'b1}) begin n_bad++; $display("FAIL ret: got %h e%b want 11 e1", dp.address, dp.stack_empty); end
    load_pc(8'h20);
    for (int i = 0; i < 4; i++) begin dp.push = 1; dp.PCload = 1; tick(); end
    n_cmp++; if ({dp.stack_full, dp.stack_err} !== 2'b10) begin n_bad++; $display("FAIL fill: got f%b e%b want f1 e0", dp.stack_full, dp.stack_err); end
    dp.push = 1; tick();
    n_cmp++; if ({dp.stack_full, dp.stack_err} !== 2'b11) begin n_bad++; $display("FAIL overflow: got f%b e%b want f1 e1", dp.stack_full, dp.stack_err); end
    load_pc(8'h00);
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if ({dp.address, dp.stack_full} !== {6'h24, 1'b0}) begin n_bad++; $display("FAIL pop_top: got %h f%b want 24 f0", dp.address, dp.stack_full); end
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if (dp.address !== 6'h23) begin n_bad++; $display("FAIL pop_lifo: got %h want 23", dp.address); end
    load_pc(8'h05);
    dp.push = 1; dp.pop = 1; tick();
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if (dp.address !== 6'h06) begin n_bad++; $display("FAIL replace_top: got %h want 06", dp.address); end
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if ({dp.address, dp.stack_empty} !== {6'h21, 1'b1}) begin n_bad++; $display("FAIL pop_last: got %h e%b want 21 e1", dp.address, dp.stack_empty); end
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if ({dp.address, dp.stack_empty, dp.stack_err} !== {6'h00, 1'b1, 1'b1}) begin n_bad++; $display("FAIL underflow: got %h e%b err%b want 00 e1 err1", dp.address, dp.stack_empty, dp.stack_err); end
    dp.push = 1; dp.pop = 1; tick();
    n_cmp++; if (dp.stack_empty !== 1'b0) begin n_bad++; $display("FAIL pushpop_empty: got e%b want e0", dp.stack_empty); end
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if ({dp.address, dp.stack_empty} !== {6'h01, 1'b1}) begin n_bad++; $display("FAIL pushpop_ret: got %h e%b want 01 e1", dp.address, dp.stack_empty); end
`else
    load_pc(8'h10);
    dp.push = 1; dp.Jmpsel = 3'd1; dp.readdata = 8'h30; dp.PCload = 1; tick();
    n_cmp++; if ({dp.address, dp.stack_full, dp.stack_empty} !== {6'h30, 1'b0, 1'b1}) begin n_bad++; $display("FAIL nostack_call: got %h f%b e%b want 30 f0 e1", dp.address, dp.stack_full, dp.stack_empty); end
    dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if (dp.address !== 6'h31) begin n_bad++; $display("FAIL nostack_sel4: got %h want 31", dp.address); end
    dp.pop = 1; tick();
    n_cmp++; if ({dp.stack_empty, dp.stack_err} !== 2'b10) begin n_bad++; $display("FAIL nostack_pop: got e%b err%b want e1 err0", dp.stack_empty, dp.stack_err); end
    load_pc(8'h3F);
    dp.push = 1; dp.pop = 1; dp.Jmpsel = 3'd4; dp.PCload = 1; tick();
    n_cmp++; if (dp.address !== 6'h00) begin n_bad++; $display("FAIL nostack_sel4_wrap: got %h want 00", dp.address); end
`endif
  endtask

  task automatic test_mid_reset();
    load_acc(8'h00); alu_op(3'd0, 2'd0);
    load_acc(8'h5A); dp.outen = 1; tick();
    load_ir(8'h77);
    load_pc(8'h15);
    dp.push = 1; tick();
    n_cmp++; if ({dp.address, dp.zflag} !== {6'h15, 1'b1}) begin n_bad++; $display("FAIL pre_reset: got %h z%b want 15 z1", dp.address, dp.zflag); end
    @(posedge clk);
    #3 reset = 1;
    #1;
    n_cmp++; if ({dp.address, dp.accout} !== {6'h00, 8'h00}) begin n_bad++; $display("FAIL async_rst_pc_acc: got %h %h want 00 00", dp.address, dp.accout); end
    n_cmp++; if ({dp.OUT, dp.INSTR} !== 16'h0000) begin n_bad++; $display("FAIL async_rst_out_ir: got %h %h want 00 00", dp.OUT, dp.INSTR); end
    n_cmp++; if ({dp.zflag, dp.cflag, dp.stack_empty, dp.stack_full} !== 4'b0010) begin n_bad++; $display("FAIL async_rst_flags: got %b want 0010", {dp.zflag, dp.cflag, dp.stack_empty, dp.stack_full}); end
    #2 reset = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_flags();
    test_shifter();
    test_rf_out();
    test_pc_wrap();
    test_stack();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
